fetch_unit: RTL and testbench

//  Instruction-fetch front end: owns the PC, issues word reads to instruction

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/fetch_unit.sv | 105 ++++++++++
 tb/tb_fetch_unit.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I constants and fetch FSM state type
//
// Purpose: widths, reset PC default, opcode/funct3 constants used by the
// decode side, and the fetch-unit state encoding.

package riscv_pkg;

  localparam int          RV_XLEN     = 32;
  localparam logic [31:0] RV_RESET_PC = 32'h0000_0000;

  localparam logic [6:0]  OP_IMM      = 7'b0010011;
  localparam logic [6:0]  OP_BRANCH   = 7'b1100011;
  localparam logic [2:0]  F3_BNE      = 3'b001;

  // IDLE: nothing outstanding; WAIT: good-path read in flight;
  // DROP: wrong-path read in flight, its data will be thrown away.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end with one-entry buffer
//
// Purpose: owns the PC, issues single-outstanding word reads to imem and
// hands one buffered instruction at a time to decode. A taken branch
// (PCsrc on an accepted instruction) redirects to instr_pc + ImmOp.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   imem_req/imem_addr       read request pulse and word address
//   imem_rvalid/imem_rdata   read response
//   instr_valid/instr_ready  decode handshake; instr, instr_pc payload
//   PCsrc, ImmOp             branch decision and offset for current instr
//   fetch_err                sticky misaligned-target / unsolicited-data flag

module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = RV_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RV_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            PCsrc,
  input  logic [XLEN-1:0] ImmOp,
  output logic            fetch_err
);

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  fetch_state_t    state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;

  logic            accept;
  logic            redirect;
  logic            misaligned;
  logic [XLEN-1:0] target;

  assign accept     = instr_valid & instr_ready;
  assign redirect   = accept & PCsrc;
  assign target     = instr_pc + ImmOp;
  assign misaligned = redirect & (target[1:0] != 2'b00);

  // The redirect target bypasses fetch_pc so the corrected fetch leaves in
  // the same cycle the branch is accepted.
  assign imem_addr = (redirect ? target : fetch_pc) & ALIGN_MASK;
  // Only issue when the buffer will be free to receive the response.
  assign imem_req  = rst_n & (state == IDLE) & (~instr_valid | accept);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      req_pc      <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      fetch_err   <= 1'b0;
    end else begin
      if (misaligned) fetch_err <= 1'b1;
      if (accept) instr_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (imem_rvalid) fetch_err <= 1'b1;
          if (imem_req) begin
            state    <= WAIT;
            fetch_pc <= imem_addr + XLEN'(4);
            req_pc   <= imem_addr;
          end
        end
        WAIT: begin
          if (redirect) begin
            fetch_pc <= target & ALIGN_MASK;
            state    <= imem_rvalid ? IDLE : DROP;
          end else if (imem_rvalid) begin
            instr       <= imem_rdata;
            instr_pc    <= req_pc;
            instr_valid <= 1'b1;
            state       <= IDLE;
          end
        end
        DROP: begin
          if (imem_rvalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_one_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    imem_req |-> (state == IDLE));
  a_addr_aligned: assert property (@(posedge clk) disable iff (!rst_n)
    imem_req |-> (imem_addr[1:0] == 2'b00));
  a_buffer_empty_on_data: assert property (@(posedge clk) disable iff (!rst_n)
    (imem_rvalid && state != IDLE) |-> !instr_valid);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit

module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        PCsrc;
  logic [31:0] ImmOp;
  logic        fetch_err;

  fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .PCsrc      (PCsrc),
    .ImmOp      (ImmOp),
    .fetch_err  (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct { int due; logic [31:0] addr; } rsp_t;
  rsp_t rsp_q[$];
  int   cyc = 0;
  int   lat = 1;
  bit   rand_lat = 0;
  int   n_req10 = 0;

  typedef struct { logic [31:0] addr; bit good; } ent_t;
  ent_t        m_q[$];
  bit          m_valid, m_err;
  logic [31:0] m_instr, m_pc, m_fetch;
  bit          use_model = 0;

  logic        s_req, s_valid, s_err;
  logic [31:0] s_addr, s_instr, s_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_valid = 0; m_err = 0;
    m_instr = 0; m_pc = 0; m_fetch = 32'h0;
  endtask

  // Transaction-level view: a list of outstanding reads tagged good/wrong-path.
  task automatic model_cycle(input bit rv, input logic [31:0] rd);
    bit accept, redir, busy, e_req;
    logic [31:0] tgt, e_addr;
    accept = m_valid && instr_ready;
    redir  = accept && PCsrc;
    tgt    = m_pc + ImmOp;
    busy   = (m_q.size() != 0);
    e_req  = !busy && (!m_valid || accept);
    e_addr = (redir ? tgt : m_fetch) & 32'hFFFF_FFFC;
    if (use_model) begin
      chk("rnd_valid", {31'b0, s_valid}, {31'b0, m_valid});
      if (m_valid) begin
        chk("rnd_instr", s_instr, m_instr);
        chk("rnd_pc", s_pc, m_pc);
      end
      chk("rnd_req", {31'b0, s_req}, {31'b0, e_req});
      if (e_req) chk("rnd_addr", s_addr, e_addr);
      chk("rnd_err", {31'b0, s_err}, {31'b0, m_err});
    end
    if (redir && tgt[1:0] != 2'b00) m_err = 1;
    if (accept) m_valid = 0;
    if (rv) begin
      if (!busy) m_err = 1;
      else begin
        if (m_q[0].good && !redir) begin
          m_valid = 1; m_instr = rd; m_pc = m_q[0].addr;
        end
        m_q.delete(0);
      end
    end
    if (redir && busy) begin
      m_fetch = tgt & 32'hFFFF_FFFC;
      if (m_q.size() != 0) m_q[0].good = 0;
    end
    if (e_req) begin
      m_q.push_back('{addr: e_addr, good: 1'b1});
      m_fetch = e_addr + 32'd4;
    end
  endtask

  // Called at a negedge: drive inputs, sample, update models, move to next negedge.
  task automatic step(input bit rdy, input bit br, input logic [31:0] imm, input bit unsol);
    bit rv;
    logic [31:0] rd;
    rv = 0; rd = 32'h0;
    if (rsp_q.size() != 0 && rsp_q[0].due == cyc) begin
      rv = 1; rd = mem_word(rsp_q[0].addr); rsp_q.delete(0);
    end else if (unsol) begin
      rv = 1; rd = $urandom;
    end
    instr_ready = rdy; PCsrc = br; ImmOp = imm;
    imem_rvalid = rv; imem_rdata = rd;
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = instr_valid;
    s_instr = instr; s_pc = instr_pc; s_err = fetch_err;
    model_cycle(rv, rd);
    if (s_req) begin
      if (rand_lat) lat = $urandom_range(1, 4);
      rsp_q.push_back('{due: cyc + lat, addr: s_addr});
      if (s_addr == 32'h10) n_req10++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rsp_q.delete();
    model_reset();
    instr_ready = 0; PCsrc = 0; ImmOp = 0; imem_rvalid = 0; imem_rdata = 0;
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", instr_pc, 32'd0);
    chk("rst_err", {31'b0, fetch_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Wait with ready low until a buffered instruction appears.
  task automatic wait_valid(input string name);
    bit seen;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0);
      seen = s_valid;
    end
    if (!seen) chk(name, 32'd0, 32'd1);
  endtask

  typedef struct {
    bit rdy; bit br; logic [31:0] imm;
    bit req; logic [31:0] addr; bit vld; logic [31:0] pc; bit err;
  } vec_t;
  vec_t tbl[14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    instr_ready = 0; PCsrc = 0; ImmOp = 0; imem_rvalid = 0; imem_rdata = 0;

    tbl[0]  = '{1, 0, 32'h0,        1, 32'h0, 0, 32'h0, 0};
    tbl[1]  = '{1, 0, 32'h0,        0, 32'h0, 0, 32'h0, 0};
    tbl[2]  = '{1, 0, 32'h0,        1, 32'h4, 1, 32'h0, 0};
    tbl[3]  = '{1, 0, 32'h0,        0, 32'h0, 0, 32'h0, 0};
    tbl[4]  = '{1, 0, 32'h0,        1, 32'h8, 1, 32'h4, 0};
    tbl[5]  = '{1, 0, 32'h0,        0, 32'h0, 0, 32'h4, 0};
    tbl[6]  = '{1, 1, 32'hFFFF_FFF8, 1, 32'h0, 1, 32'h8, 0};
    tbl[7]  = '{1, 0, 32'h0,        0, 32'h0, 0, 32'h8, 0};
    tbl[8]  = '{1, 0, 32'h0,        1, 32'h4, 1, 32'h0, 0};
    tbl[9]  = '{1, 0, 32'h0,        0, 32'h0, 0, 32'h0, 0};
    tbl[10] = '{1, 1, 32'h2,        1, 32'h4, 1, 32'h4, 0};
    tbl[11] = '{1, 0, 32'h0,        0, 32'h0, 0, 32'h4, 1};
    tbl[12] = '{1, 0, 32'h0,        1, 32'h8, 1, 32'h4, 1};
    tbl[13] = '{1, 0, 32'h0,        0, 32'h0, 0, 32'h4, 1};

    @(negedge clk);
    do_reset();

    // Streaming, backward branch, misaligned branch target
    lat = 1;
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].rdy, tbl[i].br, tbl[i].imm, 1'b0);
      chk($sformatf("t%0d_req", i), {31'b0, s_req}, {31'b0, tbl[i].req});
      if (tbl[i].req) chk($sformatf("t%0d_addr", i), s_addr, tbl[i].addr);
      chk($sformatf("t%0d_valid", i), {31'b0, s_valid}, {31'b0, tbl[i].vld});
      chk($sformatf("t%0d_pc", i), s_pc, tbl[i].pc);
      if (tbl[i].vld) chk($sformatf("t%0d_instr", i), s_instr, mem_word(tbl[i].pc));
      chk($sformatf("t%0d_err", i), {31'b0, s_err}, {31'b0, tbl[i].err});
    end

    // Decode stalls: buffer held, no request, issue on the accepting cycle
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0);
      chk("stall_valid", {31'b0, s_valid}, 32'd1);
      chk("stall_pc", s_pc, 32'h8);
      chk("stall_instr", s_instr, mem_word(32'h8));
      chk("stall_req", {31'b0, s_req}, 32'd0);
    end
    lat = 3;
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("unstall_req", {31'b0, s_req}, 32'd1);
    chk("unstall_addr", s_addr, 32'hC);

    // Slow memory, forward branch from 0xC: 0x10 must never be presented
    wait_valid("lat3_timeout_c");
    chk("lat3_pc", s_pc, 32'hC);
    step(1'b1, 1'b1, 32'h20, 1'b0);
    chk("br_req", {31'b0, s_req}, 32'd1);
    chk("br_addr", s_addr, 32'h2C);
    wait_valid("lat3_timeout_2c");
    chk("br_pc", s_pc, 32'h2C);
    chk("br_instr", s_instr, mem_word(32'h2C));
    chk("no_req_10", n_req10, 32'd0);

    // Reset while a read is in flight
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("pre_rst_req", {31'b0, s_req}, 32'd1);
    do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("post_rst_req", {31'b0, s_req}, 32'd1);
    chk("post_rst_addr", s_addr, 32'h0);

    // Unsolicited response while idle with a full buffer
    wait_valid("unsol_timeout");
    chk("unsol_pre_err", {31'b0, s_err}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("unsol_err", {31'b0, s_err}, 32'd1);
    chk("unsol_instr", s_instr, mem_word(32'h0));
    chk("unsol_pc", s_pc, 32'h0);

    // Randomised traffic against the reference model
    do_reset();
    use_model = 1;
    rand_lat = 1;
    for (int k = 0; k < 800; k++) begin
      bit rdy, br, uns;
      logic [31:0] imm;
      rdy = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 3) == 0);
      imm = (32'($urandom_range(0, 63)) << 2) - 32'd128;
      if ($urandom_range(0, 15) == 0) imm = imm + 32'($urandom_range(1, 3));
      uns = (rsp_q.size() == 0) && ($urandom_range(0, 63) == 0);
      step(rdy, br, imm, uns);
    end
    use_model = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
